// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: captures a binary value, converts it to BCD one bit
// per clock (shift-add-3), and time-multiplexes the committed digits onto a
// single BCD nibble with a one-hot digit select.
//
// Parameters
//   WIDTH     binary input width (>=1)
//   DIGITS    display digits (>=1), digit 0 least significant
//   SCAN_DIV  clocks each digit stays selected (>=1)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   value      in   [WIDTH-1:0] unsigned value to display
//   load       in   capture request, honoured only when idle
//   busy       out  conversion in progress
//   bcd        out  [3:0] nibble of the selected digit
//   digit_sel  out  [DIGITS-1:0] one-hot select of the current digit
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero digit are blanked (digit_sel forced to 0).

module bcd_display_scanner #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic [3:0]        bcd,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int VW = (WIDTH > 64) ? WIDTH : 64;

  // 10**n, saturating at all-ones once it no longer fits in 64 bits
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      if (p > 64'd1844674407370955161) return '1;
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic [WIDTH-1:0]  r_sr;
  logic [AW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic [AW-1:0]     r_dig;
  logic [DIGITS-1:0] r_blank;
  logic [DW-1:0]     r_div;
  logic [IW-1:0]     r_idx;

  logic [AW-1:0]     w_adj;
  logic [AW-1:0]     w_acc_nxt;
  logic [AW-1:0]     w_commit;
  logic [DIGITS-1:0] w_blank;
  logic              w_ovf;
  logic [3:0]        w_bcd;
  logic [DIGITS-1:0] w_sel;

  // Values that cannot be shown in DIGITS decimal places are flagged at
  // capture so COMMIT can substitute the error glyph.
  assign w_ovf = (VW'(value) >= VW'(LIMIT));

  // Add-3 correction on every nibble that would exceed 9 after doubling
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = r_acc[4*i +: 4];
    end
  end

  assign w_acc_nxt = {w_adj[AW-2:0], r_sr[WIDTH-1]};

  assign w_commit = r_ovf ? {DIGITS{4'hE}} : r_acc;

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is blank while every digit at or
  // above it is zero. Digit 0 always shows, overflow glyphs always show.
  always_comb begin
    logic z;
    z = 1'b1;
    w_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (r_acc[4*i +: 4] == 4'd0);
      w_blank[i] = z & ~r_ovf;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Conversion FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_sr    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_dig   <= '0;
      r_blank <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load) begin
            r_sr    <= value;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_ovf   <= w_ovf;
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_nxt;
          r_sr  <= r_sr << 1;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_dig   <= w_commit;
          r_blank <= w_blank;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running scan divider and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DW'(SCAN_DIV - 1)) begin
      r_div <= '0;
      if (r_idx == IW'(DIGITS - 1))
        r_idx <= '0;
      else
        r_idx <= r_idx + IW'(1);
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Register-only selection: committed digit and its select line
  always_comb begin
    w_bcd = 4'd0;
    w_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_bcd    = r_dig[4*i +: 4];
        w_sel[i] = ~r_blank[i];
      end
    end
  end

  assign busy      = r_busy;
  assign bcd       = w_bcd;
  assign digit_sel = w_sel;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed stimulus, a display-level model and
// per-cycle comparison for the 8-bit/3-digit instance, literal spot checks.

module tb_bcd_display_scanner;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic [3:0] bcd;
  logic [2:0] digit_sel;

  logic [9:0] value2;
  logic       load2;
  logic       busy2;
  logic [3:0] bcd2;
  logic [1:0] digit_sel2;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_display_scanner #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) u1 (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .bcd(bcd), .digit_sel(digit_sel)
  );

  bcd_display_scanner #(.WIDTH(10), .DIGITS(2), .SCAN_DIV(4)) u2 (
    .clk(clk), .reset(reset), .value(value2), .load(load2),
    .busy(busy2), .bcd(bcd2), .digit_sel(digit_sel2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Display-level model: a load taken while idle makes busy high for
  // WIDTH+1 clocks, then the decimal digits of the value appear.
  int m_cyc;
  int m_cnt;
  bit m_busy;
  bit m_valid = 1'b0;
  int m_dig [3];
  bit m_blank [3];
  int m_pd [3];
  bit m_pb [3];

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (reset) begin
      m_cyc  = 0;
      m_cnt  = 0;
      m_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_dig[i]   = 0;
        m_blank[i] = 1'b0;
      end
    end else begin
      m_cyc++;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          for (int i = 0; i < 3; i++) begin
            m_dig[i]   = m_pd[i];
            m_blank[i] = m_pb[i];
          end
        end
      end else if (load) begin
        int p;
        p = 1;
        for (int i = 0; i < 3; i++) begin
          if (int'(value) >= 1000) begin
            m_pd[i] = 14;
            m_pb[i] = 1'b0;
          end else begin
            m_pd[i] = (int'(value) / p) % 10;
            m_pb[i] = BLANK && (i > 0) && (int'(value) < p);
          end
          p = p * 10;
        end
        m_cnt  = 9;
        m_busy = 1'b1;
      end
    end
  end

  function automatic int idx1();
    return (m_cyc / 4) % 3;
  endfunction

  function automatic int idx2();
    return (m_cyc / 4) % 2;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      int ix;
      ix = idx1();
      check("busy", busy, m_busy);
      check("bcd", bcd, m_dig[ix]);
      check("digit_sel", digit_sel, m_blank[ix] ? 0 : (1 << ix));
    end
  end

  // Wait (bounded) for scan index k of instance 1, then check literals
  task automatic lit1(input string nm, input int k,
                      input int eb, input int es);
    int t;
    t = 0;
    while (idx1() != k && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_reach"}, (t < 20) ? 1 : 0, 1);
    check({nm, "_bcd"}, bcd, eb);
    check({nm, "_sel"}, digit_sel, es);
    check({nm, "_model"}, m_dig[k], eb);
  endtask

  task automatic lit2(input string nm, input int k,
                      input int eb, input int es);
    int t;
    t = 0;
    while (idx2() != k && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_reach"}, (t < 20) ? 1 : 0, 1);
    check({nm, "_bcd"}, bcd2, eb);
    check({nm, "_sel"}, digit_sel2, es);
  endtask

  // Called at a negedge: one-cycle load, returns the busy length
  task automatic run_load(input int v, output int c);
    value = 8'(v);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    c = 0;
    while (busy && c < 40) begin
      c++;
      @(negedge clk);
    end
  endtask

  task automatic run_load2(input int v, output int c);
    value2 = 10'(v);
    load2  = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    c = 0;
    while (busy2 && c < 40) begin
      c++;
      @(negedge clk);
    end
  endtask

  int scan_tab [13] = '{1, 1, 1, 1, 2, 2, 2, 2, 4, 4, 4, 4, 1};

  initial begin
    int c;
    reset  = 1'b1;
    value  = '0;
    load   = 1'b0;
    value2 = '0;
    load2  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_bcd", bcd, 0);
    check("rst_sel", digit_sel, 1);
    reset = 1'b0;

    // Scan sequence from reset
    for (int k = 0; k < 13; k++) begin
      check("scan_sel", digit_sel, scan_tab[k]);
      @(negedge clk);
    end

    // 237
    run_load(237, c);
    check("busy_len_237", c, 9);
    lit1("d237_0", 0, 7, 1);
    lit1("d237_1", 1, 3, 2);
    lit1("d237_2", 2, 2, 4);

    // 255 then 0
    run_load(255, c);
    check("busy_len_255", c, 9);
    lit1("d255_0", 0, 5, 1);
    lit1("d255_1", 1, 5, 2);
    lit1("d255_2", 2, 2, 4);
    run_load(0, c);
    lit1("d0_0", 0, 0, 1);
    lit1("d0_1", 1, 0, BLANK ? 0 : 2);
    lit1("d0_2", 2, 0, BLANK ? 0 : 4);

    // Load while busy, held through the commit cycle, is ignored
    value = 8'd237;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    value = 8'd5;
    @(negedge clk);
    load = 1'b1;
    c = 1;
    while (busy && c < 40) begin
      c++;
      @(negedge clk);
    end
    load = 1'b0;
    check("busy_len_ign", c, 9);
    @(negedge clk);
    @(negedge clk);
    check("busy_once", busy, 0);
    lit1("ign_0", 0, 7, 1);
    lit1("ign_1", 1, 3, 2);
    lit1("ign_2", 2, 2, 4);

    // Reset during the 4th shift cycle
    value = 8'd237;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    lit1("abort_0", 0, 0, 1);
    lit1("abort_1", 1, 0, 2);

    // Single-digit value: blanking behaviour
    run_load(7, c);
    lit1("d7_1", 1, 0, BLANK ? 0 : 2);
    lit1("d7_2", 2, 0, BLANK ? 0 : 4);
    lit1("d7_0", 0, 7, 1);

    // Ten-bit, two-digit instance: overflow and maximum
    run_load2(100, c);
    check("busy2_len", c, 11);
    lit2("ovf_0", 0, 14, 1);
    lit2("ovf_1", 1, 14, 2);
    run_load2(99, c);
    lit2("d99_0", 0, 9, 1);
    lit2("d99_1", 1, 9, 2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
